// File: rtl/sha256_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sha256_pkg
// Description : Shared types and constants for the SHA-256 message padder.
// Revision    : 1.0 - initial release
// ============================================================================
package sha256_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FILL       = 2'd0,
    EMIT       = 2'd1,
    EXTRA_EMIT = 2'd2
  } pad_state_t;

  localparam int          BLOCK_WORDS = 16;
  localparam int          LEN_WORD_HI = 14;
  localparam int          LEN_WORD_LO = 15;
  localparam logic [7:0]  PAD_MARKER  = 8'h80;

  // Clamp an out-of-range byte count to a full word.
  function automatic logic [2:0] sat_bytes(input logic [2:0] b);
    return (b > 3'd4) ? 3'd4 : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sha256_pad_word.sv
`default_nettype none
// ============================================================================
// Module      : sha256_pad_word
// Description : Masks the unused bytes of a message word and inserts the 0x80
//               marker right after the last valid byte. Flags when the marker
//               does not fit and must go into the following word.
// Revision    : 1.0 - initial release
// ============================================================================
module sha256_pad_word
  import sha256_pkg::*;
(
  input  word_t      in_data,
  input  logic [2:0] in_bytes,
  input  logic       in_last,
  output word_t      out_word,
  output logic       marker_overflow
);

  // Non-last words always carry four valid bytes.
  logic [2:0] w_bytes;
  assign w_bytes = in_last ? sat_bytes(in_bytes) : 3'd4;

  // Byte 0 is the most significant byte of the word.
  generate
    for (genvar b = 0; b < 4; b++) begin : g_byte
      assign out_word[31-8*b -: 8] = (3'(b) <  w_bytes) ? in_data[31-8*b -: 8] :
                                     (3'(b) == w_bytes) ? PAD_MARKER :
                                                          8'h00;
    end
  endgenerate

  assign marker_overflow = (w_bytes == 3'd4);

endmodule
`default_nettype wire

// File: rtl/sha256_padder.sv
`default_nettype none
// ============================================================================
// Module      : sha256_padder
// Description : Streaming SHA-256 message padder. Collects 32-bit big-endian
//               words into a 16-word buffer, applies marker, zero fill and the
//               64-bit length on the edge that accepts the last word, and
//               emits 512-bit blocks over a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module sha256_padder
  import sha256_pkg::*;
#(
  parameter int LEN_W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  in_data,
  input  logic         in_valid,
  input  logic         in_last,
  input  logic [2:0]   in_bytes,
  output logic         in_ready,
  output logic [511:0] blk_data,
  output logic         blk_valid,
  output logic         blk_last,
  input  logic         blk_ready
);

  localparam word_t c_marker_word = {PAD_MARKER, 24'h000000};

  pad_state_t       r_state;
  logic [3:0]       r_idx;
  logic [LEN_W-1:0] r_len;
  word_t            r_buf [BLOCK_WORDS];
  logic             r_last;
  logic             r_pend_extra;
  logic             r_extra_marker;

  word_t            w_pad_word;
  logic             w_marker_ovf;
  logic             w_accept;
  logic             w_blk_hs;
  logic [LEN_W-1:0] w_inc;
  logic [LEN_W-1:0] w_len_next;
  logic [63:0]      w_len_field;
  logic [63:0]      w_len_saved;
  logic [4:0]       w_marker_idx;
  logic             w_fits;
  word_t            w_fill_buf  [BLOCK_WORDS];
  word_t            w_extra_buf [BLOCK_WORDS];

  sha256_pad_word u_pad_word (
    .in_data         (in_data),
    .in_bytes        (in_bytes),
    .in_last         (in_last),
    .out_word        (w_pad_word),
    .marker_overflow (w_marker_ovf)
  );

  assign in_ready  = (r_state == FILL);
  assign blk_valid = (r_state == EMIT) || (r_state == EXTRA_EMIT);
  assign blk_last  = r_last;

  assign w_accept = in_valid & in_ready;
  assign w_blk_hs = blk_valid & blk_ready;

  assign w_inc        = in_last ? LEN_W'({sat_bytes(in_bytes), 3'b000}) : LEN_W'(32);
  assign w_len_next   = r_len + w_inc;
  assign w_len_field  = 64'(w_len_next);
  assign w_len_saved  = 64'(r_len);
  // Marker lands in the current word unless all four bytes were valid.
  assign w_marker_idx = {1'b0, r_idx} + {4'b0000, w_marker_ovf};
  assign w_fits       = (w_marker_idx <= 5'(LEN_WORD_HI - 1));

  generate
    for (genvar i = 0; i < BLOCK_WORDS; i++) begin : g_blk
      assign blk_data[511-32*i -: 32] = r_buf[i];
    end
  endgenerate

  // Next buffer contents when a word is accepted, with padding on a last word.
  always_comb begin
    for (int i = 0; i < BLOCK_WORDS; i++) begin
      w_fill_buf[i] = r_buf[i];
      if (4'(i) == r_idx) begin
        w_fill_buf[i] = w_pad_word;
      end else if (in_last && (4'(i) > r_idx)) begin
        w_fill_buf[i] = (5'(i) == w_marker_idx) ? c_marker_word : '0;
      end
    end
    if (in_last && w_fits) begin
      w_fill_buf[LEN_WORD_HI] = w_len_field[63:32];
      w_fill_buf[LEN_WORD_LO] = w_len_field[31:0];
    end
  end

  // Trailing block used when the length field did not fit in the data block.
  always_comb begin
    for (int i = 0; i < BLOCK_WORDS; i++) begin
      w_extra_buf[i] = '0;
    end
    w_extra_buf[0]           = r_extra_marker ? c_marker_word : '0;
    w_extra_buf[LEN_WORD_HI] = w_len_saved[63:32];
    w_extra_buf[LEN_WORD_LO] = w_len_saved[31:0];
  end

  // Block buffer: written on accept, swapped for the extra block or cleared on handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BLOCK_WORDS; i++) r_buf[i] <= '0;
    end else begin
      case (r_state)
        FILL: begin
          if (w_accept) r_buf <= w_fill_buf;
        end
        EMIT: begin
          if (w_blk_hs) begin
            if (r_pend_extra) r_buf <= w_extra_buf;
            else for (int i = 0; i < BLOCK_WORDS; i++) r_buf[i] <= '0;
          end
        end
        EXTRA_EMIT: begin
          if (w_blk_hs) for (int i = 0; i < BLOCK_WORDS; i++) r_buf[i] <= '0;
        end
        default: for (int i = 0; i < BLOCK_WORDS; i++) r_buf[i] <= '0;
      endcase
    end
  end

  // Control FSM: word index, length counter and block framing flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= FILL;
      r_idx          <= '0;
      r_len          <= '0;
      r_last         <= 1'b0;
      r_pend_extra   <= 1'b0;
      r_extra_marker <= 1'b0;
    end else begin
      case (r_state)
        FILL: begin
          if (w_accept) begin
            r_len <= w_len_next;
            if (in_last) begin
              r_state        <= EMIT;
              r_last         <= w_fits;
              r_pend_extra   <= !w_fits;
              r_extra_marker <= (w_marker_idx == 5'(BLOCK_WORDS));
            end else begin
              r_idx <= r_idx + 4'd1;
              if (r_idx == 4'(BLOCK_WORDS - 1)) begin
                r_state      <= EMIT;
                r_last       <= 1'b0;
                r_pend_extra <= 1'b0;
              end
            end
          end
        end
        EMIT: begin
          if (w_blk_hs) begin
            r_idx <= '0;
            if (r_pend_extra) begin
              r_state      <= EXTRA_EMIT;
              r_last       <= 1'b1;
              r_pend_extra <= 1'b0;
            end else begin
              r_state <= FILL;
              r_last  <= 1'b0;
              if (r_last) r_len <= '0;
            end
          end
        end
        EXTRA_EMIT: begin
          if (w_blk_hs) begin
            r_state        <= FILL;
            r_idx          <= '0;
            r_len          <= '0;
            r_last         <= 1'b0;
            r_extra_marker <= 1'b0;
          end
        end
        default: begin
          r_state <= FILL;
          r_idx   <= '0;
          r_len   <= '0;
          r_last  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
